inst_prefetch_buf: RTL and testbench
====================================

# inst_prefetch_buf

Parametrised instruction prefetch buffer between the core's fetch bus port and the IF/ID stage. It replaces the single-word fetch path with a DEPTH-entry queue that keeps fetching sequential words ahead of decode. It flushes and redirects on a jump. It tolerates bus responses that arrive one or more cycles after the grant.

## Interface
Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width; PC increment is DATA_W/8.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush_i  in  1  jump/redirect; empties the queue.
- flush_addr_i  in  ADDR_W  redirect target; low log2(DATA_W/8) bits forced to 0.
- fetch_req_o  out  1  fetch request.
- fetch_addr_o  out  ADDR_W  fetch address (internal PC).
- fetch_gnt_i  in  1  bus accepted request this cycle.
- fetch_rvalid_i  in  1  response data valid.
- fetch_rdata_i  in  DATA_W  response instruction.
- inst_valid_o  out  1  head entry valid.
- inst_o  out  DATA_W  head instruction.
- inst_addr_o  out  ADDR_W  head instruction address.
- inst_ready_i  in  1  consumer pops head when inst_valid_o=1.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- State: pc, out_addr (address of the outstanding request), outstanding flag, discard flag, FIFO of {addr,data}, and count.
- Only one request may be outstanding.
- fetch_req_o = !flush_i && (!outstanding || fetch_rvalid_i) && (count + outstanding) < DEPTH.
  - This is a combinational path from fetch_rvalid_i, and it gives back-to-back issue.
  - A same-cycle pop is not counted when computing free space.
- Grant (fetch_req_o && fetch_gnt_i):
  - out_addr ← pc; pc ← pc + DATA_W/8; outstanding ← 1.
  - pc wraps modulo 2^ADDR_W.
- Response (fetch_rvalid_i with outstanding):
  - If discard=0: push {out_addr, fetch_rdata_i}.
  - If discard=1: drop the data and clear discard.
  - outstanding clears unless a new grant occurs in the same cycle.
  - fetch_rvalid_i without outstanding is ignored.
- Pop: inst_valid_o && inst_ready_i advances the head. A pop when empty is impossible because inst_valid_o=0.
- Flush (highest priority):
  - count ← 0; pc ← flush_addr_i; pop is ignored.
  - If outstanding and no response this cycle: discard ← 1.
  - A response arriving in the flush cycle is dropped.
  - fetch_req_o=0 in the flush cycle.
- Simultaneous push and pop: count unchanged. Full with pop: no push can be pending beyond the reserved slot.
- No hold input: a stall is expressed by inst_ready_i=0.

## Timing
- Reset values:
  - fetch_req_o follows its equation: 1 in the first cycle after reset.
  - fetch_addr_o=RESET_PC; inst_valid_o=0; inst_o=0; inst_addr_o=0; count_o=0; outstanding=0; discard=0.
- Push at rvalid cycle t → inst_valid_o=1 at t+1. The head is read combinationally from the registered FIFO.
- Flush at t, nothing outstanding → fetch_req_o=1 with fetch_addr_o=flush_addr_i at t+1.
- Flush at t with a stale request outstanding → the new request issues in the stale rvalid cycle. Earliest is t+1.
- With a 1-cycle bus (rvalid one cycle after gnt) and inst_ready_i=1 → steady state of one instruction per cycle.
- rst asserted mid-operation → all state is back to reset values on the next edge. A response arriving afterwards is ignored.

## Structure
- Shared defines file carries the flush-address alignment mask width and the RESET_PC default beside existing bus constants.
- One sub-module, prefetch_fifo:
  - generic synchronous FIFO (WIDTH, DEPTH), pointer-based with wrap;
  - ports push, pop, clear, full, empty, count.
- Top level holds pc, outstanding, discard and the request logic.

## Test plan
- Reset, gnt=1, rvalid one cycle later, ready=1 → fetch addresses 0,4,8,…; inst_addr_o 0,4,8 on consecutive cycles after a 2-cycle startup.
- ready=0, DEPTH=4 → exactly 4 pushes, count_o=4, fetch_req_o=0. One pop → exactly one further request issues.
- Flush to 0x100 while a request to 0x8 is outstanding, rvalid two cycles later → the 0x8 data is never visible; the next request is 0x100; inst_addr_o=0x100 first.
- flush_i in the same cycle as rvalid → that data is dropped; count_o=0 next cycle; request to the flush target follows.
- flush_addr_i=0x103 → fetch_addr_o=0x100.
- gnt withheld for 5 cycles → fetch_req_o and fetch_addr_o stay stable; no push. rst asserted mid-stream → inst_valid_o=0 and fetch_addr_o=RESET_PC the following cycle.

Source files
------------

// File: rtl/inst_prefetch_buf_pkg.sv
// Shared fetch-bus constants and helpers for the instruction prefetch buffer.
package inst_prefetch_buf_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam logic [BUS_ADDR_W-1:0] DEF_RESET_PC = '0;

  // Number of low address bits forced to zero on a redirect (word alignment).
  function automatic int align_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/inst_prefetch_buf_prefetch_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head is read combinationally.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             we, re;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CNT_W'(wr_ptr - rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];
  assign we    = push && !full && !clear;
  assign re    = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch buffer: keeps one sequential fetch in flight ahead of
// decode, queues responses, and flushes/redirects on a jump.
module inst_prefetch_buf
  import inst_prefetch_buf_pkg::*;
#(
  parameter int                ADDR_W   = BUS_ADDR_W,
  parameter int                DATA_W   = BUS_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  input  logic              fetch_gnt_i,
  input  logic              fetch_rvalid_i,
  input  logic [DATA_W-1:0] fetch_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int                ALN_W    = align_w(DATA_W);
  localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALN_MASK = {ADDR_W{1'b1}} << ALN_W;
  localparam int                ENT_W    = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] pc, out_addr;
  logic              outstanding, discard;
  logic              grant, resp, push, pop, full, empty;
  logic [ENT_W-1:0]  head;
  logic [CNT_W:0]    occ;

  // The in-flight request reserves a slot; a same-cycle pop does not free one.
  assign occ          = {1'b0, count_o} + (CNT_W + 1)'(outstanding);
  assign fetch_req_o  = !flush_i && (!outstanding || fetch_rvalid_i) &&
                        (occ < (CNT_W + 1)'(DEPTH));
  assign fetch_addr_o = pc;

  assign grant = fetch_req_o && fetch_gnt_i;
  assign resp  = fetch_rvalid_i && outstanding;
  assign push  = resp && !discard && !flush_i && !full;
  assign pop   = inst_valid_o && inst_ready_i && !flush_i;

  assign inst_valid_o           = !empty;
  assign {inst_addr_o, inst_o}  = empty ? '0 : head;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      out_addr    <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (flush_i) begin
      // A request still in flight after the redirect returns stale data.
      pc          <= flush_addr_i & ALN_MASK;
      outstanding <= outstanding && !fetch_rvalid_i;
      discard     <= outstanding && !fetch_rvalid_i;
    end else begin
      if (grant) begin
        out_addr <= pc;
        pc       <= pc + PC_INC;
      end
      if (grant)     outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;
      if (resp && discard) discard <= 1'b0;
    end
  end

  prefetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (push),
    .pop   (pop),
    .wdata ({out_addr, fetch_rdata_i}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed bench for inst_prefetch_buf with a queue-based reference model.
module tb_inst_prefetch_buf;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush_i, fetch_req_o, fetch_gnt_i, fetch_rvalid_i;
  logic          inst_valid_o, inst_ready_i;
  logic [AW-1:0] flush_addr_i, fetch_addr_o, inst_addr_o;
  logic [DW-1:0] fetch_rdata_i, inst_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  inst_prefetch_buf #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o), .fetch_gnt_i(fetch_gnt_i),
    .fetch_rvalid_i(fetch_rvalid_i), .fetch_rdata_i(fetch_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i), .count_o(count_o)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int checks = 0, failures = 0, n_grants = 0, lat = 1;
  logic          g_fire = 1'b0;
  logic [AW-1:0] g_addr = '0;

  function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Bus: response arrives 'lat' cycles after the grant cycle.
  logic          pend = 1'b0;
  int            pcnt = 0;
  logic [AW-1:0] paddr = '0;
  always begin
    @(posedge clk);
    #1;
    if (fetch_rvalid_i) pend = 1'b0;
    fetch_rvalid_i = 1'b0;
    if (g_fire) begin
      pend  = 1'b1;
      pcnt  = lat;
      paddr = g_addr;
    end
    if (pend && pcnt > 0) begin
      pcnt--;
      if (pcnt == 0) begin
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = mk(paddr);
      end
    end
  end

  // Reference model: queue of {addr,data}, next pc, one in-flight flag.
  ent_t          mq[$];
  logic [AW-1:0] m_pc = '0, m_oaddr = '0;
  logic          m_out = 1'b0, m_disc = 1'b0;

  always @(negedge clk) begin : cmp
    logic          e_req, e_valid;
    logic [AW-1:0] e_iaddr;
    logic [DW-1:0] e_inst;
    int            occ;
    g_fire = (fetch_req_o === 1'b1) && (fetch_gnt_i === 1'b1);
    g_addr = fetch_addr_o;
    if (g_fire) n_grants++;
    if (rst) begin
      mq.delete();
      m_pc   = '0;
      m_out  = 1'b0;
      m_disc = 1'b0;
    end else begin
      occ     = mq.size() + (m_out ? 1 : 0);
      e_req   = !flush_i && (!m_out || fetch_rvalid_i) && (occ < DEPTH);
      e_valid = (mq.size() != 0);
      e_inst  = e_valid ? mq[0].d : '0;
      e_iaddr = e_valid ? mq[0].a : '0;
      chk("m_req", fetch_req_o, e_req);
      chk("m_faddr", fetch_addr_o, m_pc);
      chk("m_valid", inst_valid_o, e_valid);
      chk("m_inst", inst_o, e_inst);
      chk("m_iaddr", inst_addr_o, e_iaddr);
      chk("m_count", count_o, mq.size());
      if (flush_i) begin
        mq.delete();
        m_pc   = flush_addr_i & ~32'h3;
        m_disc = m_out && !fetch_rvalid_i;
        m_out  = m_out && !fetch_rvalid_i;
      end else begin
        if (e_valid && inst_ready_i) void'(mq.pop_front());
        if (fetch_rvalid_i && m_out) begin
          if (m_disc) m_disc = 1'b0;
          else mq.push_back(ent_t'{a: m_oaddr, d: fetch_rdata_i});
          m_out = 1'b0;
        end
        if (e_req && fetch_gnt_i) begin
          m_oaddr = m_pc;
          m_pc    = m_pc + 32'd4;
          m_out   = 1'b1;
        end
      end
    end
  end

  int gsnap;

  initial begin
    rst = 1'b1; flush_i = 1'b0; flush_addr_i = '0; fetch_gnt_i = 1'b0;
    inst_ready_i = 1'b0; fetch_rvalid_i = 1'b0; fetch_rdata_i = '0;
    repeat (3) nxt();
    // Streaming with a 1-cycle bus
    rst = 1'b0; fetch_gnt_i = 1'b1; inst_ready_i = 1'b1;
    @(negedge clk);
    chk("rst_req", fetch_req_o, 1);
    chk("rst_faddr", fetch_addr_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_iaddr", inst_addr_o, 0);
    chk("rst_count", count_o, 0);
    nxt();
    nxt(); @(negedge clk);
    chk("s_valid", inst_valid_o, 1);
    chk("s_iaddr0", inst_addr_o, 32'h0);
    chk("s_inst0", inst_o, mk(32'h0));
    nxt(); @(negedge clk);
    chk("s_iaddr4", inst_addr_o, 32'h4);
    nxt(); @(negedge clk);
    chk("s_iaddr8", inst_addr_o, 32'h8);
    chk("s_faddr16", fetch_addr_o, 32'h10);
    // Stall until full, then a single pop
    nxt(); inst_ready_i = 1'b0;
    repeat (5) nxt();
    gsnap = n_grants; inst_ready_i = 1'b1;
    @(negedge clk);
    chk("full_count", count_o, 4);
    chk("full_req", fetch_req_o, 0);
    nxt(); inst_ready_i = 1'b0;
    repeat (5) nxt();
    @(negedge clk);
    chk("pop_one_grant", n_grants - gsnap, 1);
    chk("refill_count", count_o, 4);
    // Flush while a request to 0x8 is outstanding (3-cycle bus)
    nxt(); rst = 1'b1; fetch_gnt_i = 1'b0;
    nxt(); nxt();
    rst = 1'b0; fetch_gnt_i = 1'b1; lat = 3;
    repeat (7) nxt();
    flush_i = 1'b1; flush_addr_i = 32'h100;
    nxt(); flush_i = 1'b0;
    @(negedge clk);
    chk("fl_faddr", fetch_addr_o, 32'h100);
    chk("fl_req_wait", fetch_req_o, 0);
    chk("fl_count", count_o, 0);
    nxt(); @(negedge clk);
    chk("fl_req_stale", fetch_req_o, 1);
    repeat (4) nxt(); @(negedge clk);
    chk("fl_valid", inst_valid_o, 1);
    chk("fl_iaddr", inst_addr_o, 32'h100);
    chk("fl_inst", inst_o, mk(32'h100));
    chk("fl_count1", count_o, 1);
    // Flush coinciding with rvalid, unaligned target
    nxt(); lat = 1;
    nxt(); flush_i = 1'b1; flush_addr_i = 32'h203;
    nxt(); flush_i = 1'b0;
    @(negedge clk);
    chk("fr_count", count_o, 0);
    chk("fr_valid", inst_valid_o, 0);
    chk("fr_faddr", fetch_addr_o, 32'h200);
    chk("fr_req", fetch_req_o, 1);
    nxt();
    nxt(); fetch_gnt_i = 1'b0;
    @(negedge clk);
    chk("fr_iaddr", inst_addr_o, 32'h200);
    // Grant withheld for 5 cycles
    for (int i = 0; i < 5; i++) begin
      nxt(); @(negedge clk);
      chk("ng_req", fetch_req_o, 1);
      chk("ng_faddr", fetch_addr_o, 32'h208);
      chk("ng_count", count_o, 2);
    end
    // Reset mid-stream with a response still in flight
    nxt(); fetch_gnt_i = 1'b1; lat = 2;
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;
    @(negedge clk);
    chk("mr_valid", inst_valid_o, 0);
    chk("mr_faddr", fetch_addr_o, 32'h0);
    chk("mr_count", count_o, 0);
    chk("mr_req", fetch_req_o, 1);
    repeat (3) nxt(); @(negedge clk);
    chk("mr_iaddr", inst_addr_o, 32'h0);
    chk("mr_valid2", inst_valid_o, 1);
    nxt(); inst_ready_i = 1'b1;
    repeat (10) nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
